// File: rtl/regfile_write_arbiter_if.sv
// Writeback bus between two requesters, issue-logic reservations and the register-file write port.
// The master side is the pipeline/bench; the slave side is the arbiter.
interface regfile_write_arbiter_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned NREG = 1 << ADDR_W;

  logic              stall;
  logic              a_valid;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;
  logic              a_ready;
  logic              b_valid;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data;
  logic              b_ready;
  logic              rsv_valid;
  logic [ADDR_W-1:0] rsv_addr;
  logic              rsv_err;
  logic              write_enable1;
  logic [ADDR_W-1:0] write_addr;
  logic [DATA_W-1:0] write_data;
  logic [NREG-1:0]   pending;

  modport master (
    output stall, a_valid, a_addr, a_data, b_valid, b_addr, b_data, rsv_valid, rsv_addr,
    input  a_ready, b_ready, rsv_err, write_enable1, write_addr, write_data, pending
  );

  modport slave (
    input  stall, a_valid, a_addr, a_data, b_valid, b_addr, b_data, rsv_valid, rsv_addr,
    output a_ready, b_ready, rsv_err, write_enable1, write_addr, write_data, pending
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU (A) and load (B)
// writeback, with a registered write stage and a pending-write scoreboard.
module regfile_write_arbiter #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 32
) (
  input logic                    clk,
  input logic                    rst,
  regfile_write_arbiter_if.slave bus
);
  localparam int unsigned NREG = 1 << ADDR_W;

  typedef enum logic {GrantA, GrantB} grant_e;

  grant_e            last_grant_q, last_grant_d;
  logic              a_ready, b_ready, a_xfer, b_xfer;
  logic              write_enable1_q, write_enable1_d;
  logic [ADDR_W-1:0] write_addr_q, write_addr_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic [NREG-1:0]   pending_q, pending_d;
  logic              rsv_err_q, rsv_err_d;

  // Ready depends only on inputs and last_grant, never on the write stage.
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (rst && !bus.stall) begin
      if (bus.a_valid && bus.b_valid) begin
        if (last_grant_q == GrantB) a_ready = 1'b1;
        else                        b_ready = 1'b1;
      end else begin
        a_ready = bus.a_valid;
        b_ready = bus.b_valid;
      end
    end
  end

  assign a_xfer = bus.a_valid && a_ready;
  assign b_xfer = bus.b_valid && b_ready;

  always_comb begin
    last_grant_d    = last_grant_q;
    write_enable1_d = a_xfer || b_xfer;
    write_addr_d    = write_addr_q;
    write_data_d    = write_data_q;
    pending_d       = pending_q;
    if (a_xfer) begin
      last_grant_d            = GrantA;
      write_addr_d            = bus.a_addr;
      write_data_d            = bus.a_data;
      pending_d[bus.a_addr]   = 1'b0;
    end else if (b_xfer) begin
      last_grant_d            = GrantB;
      write_addr_d            = bus.b_addr;
      write_data_d            = bus.b_data;
      pending_d[bus.b_addr]   = 1'b0;
    end
    // Reservation applied after the clear so a new producer wins a same-edge collision.
    if (bus.rsv_valid) pending_d[bus.rsv_addr] = 1'b1;
    rsv_err_d = bus.rsv_valid && pending_q[bus.rsv_addr];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q    <= GrantB;
      write_enable1_q <= 1'b0;
      write_addr_q    <= '0;
      write_data_q    <= '0;
      pending_q       <= '0;
      rsv_err_q       <= 1'b0;
    end else begin
      last_grant_q    <= last_grant_d;
      write_enable1_q <= write_enable1_d;
      write_addr_q    <= write_addr_d;
      write_data_q    <= write_data_d;
      pending_q       <= pending_d;
      rsv_err_q       <= rsv_err_d;
    end
  end

  assign bus.a_ready       = a_ready;
  assign bus.b_ready       = b_ready;
  assign bus.write_enable1 = write_enable1_q;
  assign bus.write_addr    = write_addr_q;
  assign bus.write_data    = write_data_q;
  assign bus.pending       = pending_q;
  assign bus.rsv_err       = rsv_err_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: handshake, round-robin, stall, scoreboard, async reset.
module tb_regfile_write_arbiter;
  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  logic [31:0] rf [16];

  regfile_write_arbiter_if bus ();

  regfile_write_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference register file fed by the write port.
  always @(posedge clk) if (bus.write_enable1) rf[bus.write_addr] <= bus.write_data;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.stall = 1'b0; bus.a_valid = 1'b0; bus.b_valid = 1'b0; bus.rsv_valid = 1'b0;
    bus.a_addr = '0; bus.a_data = '0; bus.b_addr = '0; bus.b_data = '0; bus.rsv_addr = '0;
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    #2;
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    bus.a_valid = 1'b1;
    #2;
    vectors++; if (bus.write_enable1 !== 1'b0) begin miscompares++; $display("FAIL reset_we: got %b want 0", bus.write_enable1); end
    vectors++; if (bus.write_addr !== 4'd0) begin miscompares++; $display("FAIL reset_addr: got %0d want 0", bus.write_addr); end
    vectors++; if (bus.write_data !== 32'd0) begin miscompares++; $display("FAIL reset_data: got %h want 0", bus.write_data); end
    vectors++; if (bus.pending !== 16'h0000) begin miscompares++; $display("FAIL reset_pending: got %h want 0000", bus.pending); end
    vectors++; if (bus.rsv_err !== 1'b0) begin miscompares++; $display("FAIL reset_rsv_err: got %b want 0", bus.rsv_err); end
    vectors++; if (bus.a_ready !== 1'b0) begin miscompares++; $display("FAIL reset_a_ready: got %b want 0", bus.a_ready); end
    bus.a_valid = 1'b0;
    step();
    rst = 1'b1;
  endtask

  task automatic test_single();
    bus.a_valid = 1'b1; bus.a_addr = 4'd3; bus.a_data = 32'h1111_1111;
    #1;
    vectors++; if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0) begin miscompares++; $display("FAIL single_ready: got a=%b b=%b want a=1 b=0", bus.a_ready, bus.b_ready); end
    step();
    bus.a_valid = 1'b0;
    vectors++; if (bus.write_enable1 !== 1'b1 || bus.write_addr !== 4'd3 || bus.write_data !== 32'h1111_1111) begin miscompares++; $display("FAIL single_write: got we=%b addr=%0d data=%h want we=1 addr=3 data=11111111", bus.write_enable1, bus.write_addr, bus.write_data); end
    step();
    vectors++; if (bus.write_enable1 !== 1'b0 || bus.write_addr !== 4'd3 || bus.write_data !== 32'h1111_1111) begin miscompares++; $display("FAIL single_idle_hold: got we=%b addr=%0d data=%h want we=0 addr=3 data=11111111", bus.write_enable1, bus.write_addr, bus.write_data); end
  endtask

  task automatic test_round_robin();
    logic [3:0]  exp_addr;
    logic [31:0] exp_data;
    pulse_reset();
    bus.a_valid = 1'b1; bus.a_addr = 4'd1; bus.a_data = 32'hA;
    bus.b_valid = 1'b1; bus.b_addr = 4'd2; bus.b_data = 32'hB;
    for (int i = 0; i < 4; i++) begin
      #1;
      vectors++; if (bus.a_ready !== (i % 2 == 0) || bus.b_ready !== (i % 2 == 1)) begin miscompares++; $display("FAIL rr_grant%0d: got a=%b b=%b want a=%0d b=%0d", i, bus.a_ready, bus.b_ready, (i % 2 == 0), (i % 2 == 1)); end
      step();
      exp_addr = (i % 2 == 0) ? 4'd1 : 4'd2;
      exp_data = (i % 2 == 0) ? 32'hA : 32'hB;
      vectors++; if (bus.write_enable1 !== 1'b1 || bus.write_addr !== exp_addr || bus.write_data !== exp_data) begin miscompares++; $display("FAIL rr_write%0d: got we=%b addr=%0d data=%h want we=1 addr=%0d data=%h", i, bus.write_enable1, bus.write_addr, bus.write_data, exp_addr, exp_data); end
    end
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    step();
  endtask

  task automatic test_same_addr();
    // last grant is B here, so A wins the tie.
    bus.a_valid = 1'b1; bus.a_addr = 4'd5; bus.a_data = 32'h5A;
    bus.b_valid = 1'b1; bus.b_addr = 4'd5; bus.b_data = 32'h5B;
    #1;
    vectors++; if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0) begin miscompares++; $display("FAIL same_grant_a: got a=%b b=%b want a=1 b=0", bus.a_ready, bus.b_ready); end
    step();
    bus.a_valid = 1'b0;
    vectors++; if (bus.write_enable1 !== 1'b1 || bus.write_addr !== 4'd5 || bus.write_data !== 32'h5A) begin miscompares++; $display("FAIL same_write_a: got we=%b addr=%0d data=%h want we=1 addr=5 data=5a", bus.write_enable1, bus.write_addr, bus.write_data); end
    vectors++; if (bus.b_ready !== 1'b1) begin miscompares++; $display("FAIL same_grant_b: got b=%b want 1", bus.b_ready); end
    step();
    bus.b_valid = 1'b0;
    vectors++; if (bus.write_enable1 !== 1'b1 || bus.write_addr !== 4'd5 || bus.write_data !== 32'h5B) begin miscompares++; $display("FAIL same_write_b: got we=%b addr=%0d data=%h want we=1 addr=5 data=5b", bus.write_enable1, bus.write_addr, bus.write_data); end
    step();
    vectors++; if (rf[5] !== 32'h5B) begin miscompares++; $display("FAIL same_final_r5: got %h want 5b", rf[5]); end
  endtask

  task automatic test_stall();
    // last grant is B: A wins this tie and its write is in flight when stall rises.
    bus.a_valid = 1'b1; bus.a_addr = 4'd1; bus.a_data = 32'hA;
    bus.b_valid = 1'b1; bus.b_addr = 4'd2; bus.b_data = 32'hB;
    step();
    bus.stall = 1'b1;
    #1;
    vectors++; if (bus.write_enable1 !== 1'b1 || bus.write_addr !== 4'd1) begin miscompares++; $display("FAIL stall_drain: got we=%b addr=%0d want we=1 addr=1", bus.write_enable1, bus.write_addr); end
    for (int k = 0; k < 3; k++) begin
      vectors++; if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0) begin miscompares++; $display("FAIL stall_ready%0d: got a=%b b=%b want 0 0", k, bus.a_ready, bus.b_ready); end
      step();
      vectors++; if (bus.write_enable1 !== 1'b0 || bus.write_addr !== 4'd1 || bus.write_data !== 32'hA) begin miscompares++; $display("FAIL stall_we%0d: got we=%b addr=%0d data=%h want we=0 addr=1 data=a", k, bus.write_enable1, bus.write_addr, bus.write_data); end
    end
    bus.stall = 1'b0;
    #1;
    vectors++; if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b1) begin miscompares++; $display("FAIL stall_resume: got a=%b b=%b want a=0 b=1", bus.a_ready, bus.b_ready); end
    step();
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    vectors++; if (bus.write_enable1 !== 1'b1 || bus.write_addr !== 4'd2 || bus.write_data !== 32'hB) begin miscompares++; $display("FAIL stall_resume_write: got we=%b addr=%0d data=%h want we=1 addr=2 data=b", bus.write_enable1, bus.write_addr, bus.write_data); end
    step();
  endtask

  task automatic test_scoreboard();
    vectors++; if (bus.pending !== 16'h0000) begin miscompares++; $display("FAIL sb_nonpending_xfer: got %h want 0000", bus.pending); end
    bus.rsv_valid = 1'b1; bus.rsv_addr = 4'd7;
    step();
    vectors++; if (bus.pending !== 16'h0080 || bus.rsv_err !== 1'b0) begin miscompares++; $display("FAIL sb_rsv7: got pending=%h err=%b want 0080 0", bus.pending, bus.rsv_err); end
    step();
    bus.rsv_valid = 1'b0;
    vectors++; if (bus.pending !== 16'h0080 || bus.rsv_err !== 1'b1) begin miscompares++; $display("FAIL sb_double_rsv: got pending=%h err=%b want 0080 1", bus.pending, bus.rsv_err); end
    step();
    vectors++; if (bus.rsv_err !== 1'b0) begin miscompares++; $display("FAIL sb_err_pulse: got %b want 0", bus.rsv_err); end
    bus.rsv_valid = 1'b1; bus.b_valid = 1'b1; bus.b_addr = 4'd7; bus.b_data = 32'h77;
    step();
    bus.rsv_valid = 1'b0; bus.b_valid = 1'b0;
    vectors++; if (bus.pending !== 16'h0080 || bus.write_enable1 !== 1'b1 || bus.write_addr !== 4'd7) begin miscompares++; $display("FAIL sb_set_wins: got pending=%h we=%b addr=%0d want 0080 1 7", bus.pending, bus.write_enable1, bus.write_addr); end
    bus.a_valid = 1'b1; bus.a_addr = 4'd7; bus.a_data = 32'h78;
    step();
    bus.a_valid = 1'b0;
    vectors++; if (bus.pending !== 16'h0000) begin miscompares++; $display("FAIL sb_clear: got %h want 0000", bus.pending); end
    step();
  endtask

  task automatic test_reset_midflight();
    bus.a_valid = 1'b1; bus.a_addr = 4'd9; bus.a_data = 32'h99;
    bus.rsv_valid = 1'b1; bus.rsv_addr = 4'd12;
    step();
    bus.a_valid = 1'b0; bus.rsv_valid = 1'b0;
    vectors++; if (bus.write_enable1 !== 1'b1 || bus.pending !== 16'h1000) begin miscompares++; $display("FAIL mid_inflight: got we=%b pending=%h want 1 1000", bus.write_enable1, bus.pending); end
    rst = 1'b0;
    #1;
    vectors++; if (bus.write_enable1 !== 1'b0 || bus.pending !== 16'h0000) begin miscompares++; $display("FAIL mid_async_clear: got we=%b pending=%h want 0 0000", bus.write_enable1, bus.pending); end
    bus.a_valid = 1'b1; bus.a_addr = 4'd4; bus.a_data = 32'h44;
    bus.b_valid = 1'b1; bus.b_addr = 4'd6; bus.b_data = 32'h66;
    #1;
    vectors++; if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0) begin miscompares++; $display("FAIL mid_ready_in_reset: got a=%b b=%b want 0 0", bus.a_ready, bus.b_ready); end
    rst = 1'b1;
    #1;
    vectors++; if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0) begin miscompares++; $display("FAIL mid_first_tie: got a=%b b=%b want a=1 b=0", bus.a_ready, bus.b_ready); end
    step();
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    vectors++; if (bus.write_enable1 !== 1'b1 || bus.write_addr !== 4'd4 || bus.write_data !== 32'h44) begin miscompares++; $display("FAIL mid_after_write: got we=%b addr=%0d data=%h want 1 4 44", bus.write_enable1, bus.write_addr, bus.write_data); end
    step();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    step();
    test_single();
    test_round_robin();
    test_same_addr();
    test_stall();
    test_scoreboard();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single write port of the 16 x 32-bit CPU register file between two writeback requesters: A (ALU result) and B (load/memory result).
- Arbitrates round-robin under valid/ready handshakes and drives a registered write strobe, address and data into the register file.
- Keeps a 16-bit pending-write scoreboard so issue logic can detect RAW hazards on registers with outstanding writes.

Parameters:
- ADDR_W, 4, register address width; NREG = 2**ADDR_W registers.
- DATA_W, 32, register data width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall  in  1  freezes granting while high.
- a_valid  in  1  requester A has a write.
- a_addr  in  ADDR_W  A destination register.
- a_data  in  DATA_W  A write data.
- a_ready  out  1  A handshake accepted this cycle.
- b_valid  in  1  requester B has a write.
- b_addr  in  ADDR_W  B destination register.
- b_data  in  DATA_W  B write data.
- b_ready  out  1  B handshake accepted this cycle.
- rsv_valid  in  1  issue logic reserves a destination register.
- rsv_addr  in  ADDR_W  register being reserved.
- rsv_err  out  1  one-cycle pulse: the reservation hit an already-pending register.
- write_enable1  out  1  register-file write strobe, registered.
- write_addr  out  ADDR_W  register-file write address, registered.
- write_data  out  DATA_W  register-file write data, registered.
- pending  out  NREG  scoreboard: bit i set means a write to register i is outstanding.

Behaviour:
- Reset (rst low, asynchronous): write_enable1=0, write_addr=0, write_data=0, pending=0, rsv_err=0, last_grant=B (so A wins the first tie). Ready outputs are combinational and read 0 while in reset.
- Handshake: a transfer occurs on a rising edge where valid && ready. Ready is combinational from the valid inputs, stall and last_grant. Requesters must hold addr and data stable while valid && !ready.
- Arbitration, when stall=0:
  - only A valid -> a_ready=1;
  - only B valid -> b_ready=1;
  - both valid -> grant the requester not equal to last_grant;
  - neither valid -> both ready=0.
  - At most one ready is high per cycle.
- last_grant updates only on a transfer.
- stall=1: a_ready=b_ready=0 and no transfer. The output stage still completes any write accepted in the previous cycle.
- Latency: a transfer at edge N produces write_enable1=1 with that addr/data for exactly the cycle following edge N. Without a transfer, write_enable1=0 and write_addr/write_data hold their last values.
- Throughput: one write per cycle. A single continuously valid requester is accepted every cycle.
- Same address from A and B in the same cycle: only the granted one is written. The loser is written at the earliest the next cycle. Write order follows grant order.
- Scoreboard:
  - A rsv_valid cycle sets pending[rsv_addr] at the edge.
  - A transfer clears pending[addr of transferred request] at the same edge.
  - Set and clear of the same bit at the same edge: set wins (new producer).
  - rsv_valid when pending[rsv_addr] is already 1: the bit stays 1 and rsv_err pulses high the following cycle.
  - A transfer to a non-pending register is legal; its bit stays 0.
- Reset mid-operation: the in-flight output write is dropped (write_enable1 forced to 0) and all pending bits clear. Requesters must re-present after reset.
- No combinational path from write_* outputs back to the ready outputs.

Test Plan:
- Reset, then a_valid=1 with a_addr=3, a_data=0x11111111 for one cycle -> a_ready=1 that cycle; next cycle write_enable1=1, write_addr=3, write_data=0x11111111; following cycle write_enable1=0.
- A and B both valid continuously (A: addr 1, data 0xA; B: addr 2, data 0xB) for 4 cycles -> grants A,B,A,B; write_enable1 high every cycle, one cycle behind each grant.
- A and B both target register 5 (A data 0x5A, B data 0x5B) -> A written first, then B; register 5 finally holds 0x5B.
- stall=1 for 3 cycles with both valid -> no ready and write_enable1=0 after the in-flight write drains; on stall=0 arbitration resumes with the requester not equal to last_grant.
- rsv_valid addr 7 -> pending=0x0080; rsv_valid addr 7 again -> rsv_err pulses; B transfer to addr 7 in the same cycle as a new rsv of 7 -> pending[7] remains 1; a later transfer to 7 -> pending=0.
- Assert rst low while a write is in flight -> write_enable1=0 and pending=0 immediately, without waiting for clk; after release, A wins the first tie.
